// File: rtl/div_period_meter.sv
// Period / high-time monitor for the clock divider output, checked against 2*div.
// Optional macro DIV_METER_DUTY_EN: also require high time == div for a match.
module div_period_meter #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             q,
    input  logic [2:0]       div,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             match,
    output logic             locked,
    output logic             err
);

    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       LOCK_MAX = 4'(LOCK_CNT);

    state_t           state;
    logic             q_d;
    logic [2:0]       div_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [3:0]       lock_cnt;

    logic             rise;
    logic             div_chg;
    logic             cmp_en;
    logic             hit;
    logic [CNT_W-1:0] exp_period;
    logic [3:0]       lock_nxt;

    assign rise       = q & ~q_d;
    assign div_chg    = (div != div_d);
    assign cmp_en     = (div >= 3'd2);
    assign exp_period = CNT_W'({div, 1'b0});
    assign lock_nxt   = (lock_cnt == LOCK_MAX) ? LOCK_MAX : lock_cnt + 4'd1;

`ifdef DIV_METER_DUTY_EN
    assign hit = (cnt == exp_period) && (hcnt == CNT_W'(div));
`else
    assign hit = (cnt == exp_period);
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= IDLE;
            q_d        <= 1'b0;
            div_d      <= 3'd0;
            cnt        <= '0;
            hcnt       <= '0;
            lock_cnt   <= 4'd0;
            meas_valid <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            match      <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
        end else begin
            q_d        <= q;
            div_d      <= div;
            meas_valid <= 1'b0;
            if (div_chg) begin
                // A ratio switch restarts measurement; any rise this cycle is dropped.
                state    <= IDLE;
                locked   <= 1'b0;
                lock_cnt <= 4'd0;
                match    <= 1'b0;
            end else begin
                // Lock bookkeeping runs on the cycle the result is presented.
                if (meas_valid && (div_d >= 3'd2)) begin
                    if (match) begin
                        lock_cnt <= lock_nxt;
                        locked   <= (lock_nxt == LOCK_MAX);
                    end else begin
                        if (locked)
                            err <= 1'b1;
                        lock_cnt <= 4'd0;
                        locked   <= 1'b0;
                    end
                end
                case (state)
                    IDLE: begin
                        if (rise) begin
                            cnt   <= CNT_W'(1);
                            hcnt  <= CNT_W'(1);
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            period     <= cnt;
                            high_time  <= hcnt;
                            meas_valid <= 1'b1;
                            match      <= cmp_en && hit;
                            cnt        <= CNT_W'(1);
                            hcnt       <= CNT_W'(1);
                        end else if (cnt == CNT_MAX) begin
                            err      <= 1'b1;
                            locked   <= 1'b0;
                            lock_cnt <= 4'd0;
                            state    <= IDLE;
                        end else begin
                            cnt  <= cnt + CNT_W'(1);
                            hcnt <= hcnt + CNT_W'(q);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_period_meter.sv
// Scoreboard bench for div_period_meter: rise-timestamp reference model, randomized q/div streams.
module tb_div_period_meter;

    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 4;
    localparam int MAXC     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             clear = 1'b1;
    logic             q = 1'b0;
    logic [2:0]       div = 3'd0;
    logic             meas_valid;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             match;
    logic             locked;
    logic             err;

    div_period_meter #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
        .clk(clk), .clear(clear), .q(q), .div(div),
        .meas_valid(meas_valid), .period(period), .high_time(high_time),
        .match(match), .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {int p; int h; bit m;} meas_t;
    meas_t sbq[$];

    int checks = 0;
    int failures = 0;

    // reference model: history of q per cycle plus timestamp of the last usable rise
    bit qh[$];
    int k = 0;
    int t0 = -1;
    int lockc = 0;
    int m_prev_div = 0;
    bit m_prev_q = 0, m_locked = 0, m_err = 0, m_match = 0;
    bit pend = 0, pend_m = 0, pend_en = 0;
    bit nxt_mv = 0, nxt_clr = 0, nxt_on = 0;
    bit cur_mv = 0, cur_clr = 0, cur_locked = 0, cur_err = 0, cur_match = 0, chk_on = 0;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_step(input bit qv, input int dv, input bit cv);
        bit rise, chg, en, mm;
        int p, h;
        en = 0; mm = 0;
        nxt_mv = 0;
        nxt_clr = cv;
        if (cv) begin
            t0 = -1; lockc = 0; m_locked = 0; m_err = 0; m_match = 0; pend = 0;
            m_prev_q = 0; m_prev_div = 0;
        end else begin
            rise = qv && !m_prev_q;
            chg  = (dv != m_prev_div);
            if (chg) begin
                t0 = -1; lockc = 0; m_locked = 0; m_match = 0; pend = 0;
            end else begin
                if (pend && pend_en) begin
                    if (pend_m) begin
                        if (lockc < LOCK_CNT) lockc++;
                        if (lockc == LOCK_CNT) m_locked = 1;
                    end else begin
                        if (m_locked) m_err = 1;
                        lockc = 0;
                        m_locked = 0;
                    end
                end
                if (rise && t0 >= 0) begin
                    p = k - t0;
                    h = 0;
                    for (int i = t0; i < k; i++) h += int'(qh[i]);
                    en = (dv >= 2);
`ifdef DIV_METER_DUTY_EN
                    mm = en && (p == 2 * dv) && (h == dv);
`else
                    mm = en && (p == 2 * dv);
`endif
                    m_match = mm;
                    sbq.push_back('{p, h, mm});
                    nxt_mv = 1;
                    t0 = k;
                end else if (rise) begin
                    t0 = k;
                end else if (t0 >= 0 && (k - t0) == MAXC) begin
                    m_err = 1; m_locked = 0; lockc = 0; t0 = -1;
                end
                pend = nxt_mv; pend_m = mm; pend_en = en;
            end
            m_prev_q = qv;
            m_prev_div = dv;
        end
        qh.push_back(qv);
        k++;
    endtask

    task automatic cyc(input bit qv, input int dv, input bit cv);
        @(posedge clk);
        #1;
        cur_mv = nxt_mv; cur_clr = nxt_clr; cur_locked = m_locked;
        cur_err = m_err; cur_match = m_match; chk_on = nxt_on;
        q = qv; div = dv[2:0]; clear = cv;
        model_step(qv, dv, cv);
        nxt_on = 1;
    endtask

    task automatic per(input int p, input int h, input int dv);
        for (int i = 0; i < p; i++) cyc(i < h, dv, 1'b0);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            meas_t e;
            chk("meas_valid", int'(meas_valid), int'(cur_mv));
            chk("locked", int'(locked), int'(cur_locked));
            chk("err", int'(err), int'(cur_err));
            chk("match", int'(match), int'(cur_match));
            if (cur_clr) begin
                chk("reset_period", int'(period), 0);
                chk("reset_high_time", int'(high_time), 0);
            end
            if (meas_valid || cur_mv) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    if (meas_valid) begin
                        chk("sb_period", int'(period), e.p);
                        chk("sb_high_time", int'(high_time), e.h);
                        chk("sb_match", int'(match), int'(e.m));
                    end
                end
            end
        end
    end

    initial begin
        int dv, n, r, p, h, dv2, s;
        cyc(0, 2, 1); cyc(0, 2, 1);
        repeat (7) per(4, 2, 2);
        repeat (7) per(6, 3, 3);
        repeat (6) per(4, 2, 2);
        per(5, 3, 2);
        repeat (3) per(4, 2, 2);
        per(300, 1, 2);
        repeat (3) per(4, 2, 2);
        cyc(0, 4, 1);
        repeat (2) per(8, 4, 4);
        for (int i = 0; i < 8; i++) cyc(i < 4, 4, i == 3);
        repeat (3) per(8, 4, 4);
        repeat (6) per(6, 2, 3);
        repeat (40) begin
            dv = $urandom_range(0, 7);
            n  = $urandom_range(1, 8);
            if ($urandom_range(0, 19) == 0) cyc(0, dv, 1);
            repeat (n) begin
                r = $urandom_range(0, 9);
                if (dv >= 1 && r < 7) begin
                    per(2 * dv, dv, dv);
                end else if (r == 9 && $urandom_range(0, 3) == 0) begin
                    per(256 + $urandom_range(0, 20), 1, dv);
                end else if (r == 8) begin
                    p = $urandom_range(4, 14); h = $urandom_range(1, p - 1);
                    dv2 = $urandom_range(0, 7); s = $urandom_range(0, p - 1);
                    for (int i = 0; i < p; i++) cyc(i < h, (i < s) ? dv : dv2, 1'b0);
                    dv = dv2;
                end else begin
                    p = $urandom_range(2, 16); h = $urandom_range(1, p - 1);
                    per(p, h, dv);
                end
            end
        end
        repeat (3) cyc(0, int'(div), 0);
        chk("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
